// File: rtl/change_dispenser_if.sv
// -----------------------------------------------------------------------------
// change_dispenser_if
// Bundles the vending-FSM, hopper, refill and status signals of the change
// dispenser so that one port carries the whole bus.
//   master : the environment (vending FSM, hopper, service panel) that drives
//            the request/refill/clear inputs and observes status
//   slave  : the dispenser itself
// Signals (widths in bits):
//   charge_ind(1)  coin_sum(6, Q1)  eject_ack(1)  refill(1)  refill_type(2)
//   refill_cnt(4)  clear(1)  eject_req(1)  eject_type(2)  busy(1)  done(1)
//   fault(1)  remain(6, Q1)  tube_0p5/tube_1/tube_5(4 each)
// Coin encoding: 01 = 0.5 yuan, 11 = 1 yuan, 10 = 5 yuan, 00 = none.
// -----------------------------------------------------------------------------
interface change_dispenser_if;
    logic       charge_ind;
    logic [5:0] coin_sum;
    logic       eject_ack;
    logic       refill;
    logic [1:0] refill_type;
    logic [3:0] refill_cnt;
    logic       clear;
    logic       eject_req;
    logic [1:0] eject_type;
    logic       busy;
    logic       done;
    logic       fault;
    logic [5:0] remain;
    logic [3:0] tube_0p5;
    logic [3:0] tube_1;
    logic [3:0] tube_5;

    modport master (
        output charge_ind, coin_sum, eject_ack, refill, refill_type, refill_cnt, clear,
        input  eject_req, eject_type, busy, done, fault, remain, tube_0p5, tube_1, tube_5
    );

    modport slave (
        input  charge_ind, coin_sum, eject_ack, refill, refill_type, refill_cnt, clear,
        output eject_req, eject_type, busy, done, fault, remain, tube_0p5, tube_1, tube_5
    );
endinterface

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
// Pays out a change amount (in half-yuan units) one coin at a time from three
// tubes (5, 1 and 0.5 yuan), largest coin first, through a request/acknowledge
// handshake with the hopper. Tracks tube inventory, accepts refills while not
// paying out, and enters FAULT on an empty-tube dead end or a hopper timeout.
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   io_bus : change_dispenser_if.slave (see the interface file for signals)
// Parameters:
//   TUBE_INIT   : coins loaded into each tube at reset
//   ACK_TIMEOUT : EJECT cycles allowed without eject_ack before FAULT
// -----------------------------------------------------------------------------
module change_dispenser #(
    parameter int TUBE_INIT   = 10,
    parameter int ACK_TIMEOUT = 200
) (
    input  logic               clk,
    input  logic               rst_n,
    change_dispenser_if.slave  io_bus
);

    // The timer only ever holds 0 .. ACK_TIMEOUT-1.
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_0P5  = 2'b01,
        COIN_5    = 2'b10,
        COIN_1    = 2'b11
    } coin_t;

    state_t          r_state,      w_state_next;
    coin_t           r_sel,        w_sel_next;
    logic [5:0]      r_remain,     w_remain_next;
    logic [TW-1:0]   r_timer,      w_timer_next;
    logic [3:0]      r_tube_0p5,   w_tube_0p5_next;
    logic [3:0]      r_tube_1,     w_tube_1_next;
    logic [3:0]      r_tube_5,     w_tube_5_next;
    logic            r_charge_prev;

    logic            w_charge_rise;
    logic            w_refill_ok;

    // Value of a coin in half-yuan units.
    function automatic logic [5:0] coin_value(input coin_t c);
        case (c)
            COIN_5:   return 6'd10;
            COIN_1:   return 6'd2;
            COIN_0P5: return 6'd1;
            default:  return 6'd0;
        endcase
    endfunction

    // Tube capacity is 15; refills clip rather than wrap.
    function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[4] ? 4'd15 : s[3:0];
    endfunction

    assign w_charge_rise = io_bus.charge_ind && !r_charge_prev;
    // Refills are only safe while no coin selection is in flight.
    assign w_refill_ok   = io_bus.refill && ((r_state == S_IDLE) || (r_state == S_FAULT));

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (which would infer a latch).
        w_state_next    = r_state;
        w_sel_next      = r_sel;
        w_remain_next   = r_remain;
        w_timer_next    = r_timer;
        w_tube_0p5_next = r_tube_0p5;
        w_tube_1_next   = r_tube_1;
        w_tube_5_next   = r_tube_5;

        case (r_state)
            S_IDLE: begin
                if (w_charge_rise) begin
                    w_remain_next = io_bus.coin_sum;
                    w_state_next  = S_SELECT;
                end
            end

            S_SELECT: begin
                w_timer_next = '0;
                // Each branch guarantees remain >= the chosen coin value, so
                // the later subtraction cannot underflow.
                if (r_remain == 6'd0) begin
                    w_state_next = S_DONE;
                end else if (r_remain >= 6'd10 && r_tube_5 != 4'd0) begin
                    w_sel_next   = COIN_5;
                    w_state_next = S_EJECT;
                end else if (r_remain >= 6'd2 && r_tube_1 != 4'd0) begin
                    w_sel_next   = COIN_1;
                    w_state_next = S_EJECT;
                end else if (r_tube_0p5 != 4'd0) begin
                    w_sel_next   = COIN_0P5;
                    w_state_next = S_EJECT;
                end else begin
                    w_state_next = S_FAULT;
                end
            end

            S_EJECT: begin
                // An ack on the last allowed cycle still counts as delivered.
                if (io_bus.eject_ack) begin
                    w_remain_next = r_remain - coin_value(r_sel);
                    case (r_sel)
                        COIN_5:   w_tube_5_next   = r_tube_5   - 4'd1;
                        COIN_1:   w_tube_1_next   = r_tube_1   - 4'd1;
                        COIN_0P5: w_tube_0p5_next = r_tube_0p5 - 4'd1;
                        default:  ;
                    endcase
                    w_state_next = S_GAP;
                end else if (r_timer == TW'(ACK_TIMEOUT - 1)) begin
                    w_state_next = S_FAULT;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end

            S_GAP: begin
                // Wait for the hopper to release ack so one ack never counts twice.
                if (!io_bus.eject_ack) begin
                    w_state_next = S_SELECT;
                end
            end

            S_DONE: begin
                w_state_next = S_IDLE;
            end

            S_FAULT: begin
                if (io_bus.clear) begin
                    w_remain_next = 6'd0;
                    w_state_next  = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Only IDLE/FAULT reach here with a refill, and neither touches the
        // tubes above, so a refill never collides with a decrement.
        if (w_refill_ok) begin
            case (io_bus.refill_type)
                COIN_0P5: w_tube_0p5_next = sat_add(r_tube_0p5, io_bus.refill_cnt);
                COIN_1:   w_tube_1_next   = sat_add(r_tube_1,   io_bus.refill_cnt);
                COIN_5:   w_tube_5_next   = sat_add(r_tube_5,   io_bus.refill_cnt);
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_sel         <= COIN_NONE;
            r_remain      <= 6'd0;
            r_timer       <= '0;
            r_tube_0p5    <= 4'(TUBE_INIT);
            r_tube_1      <= 4'(TUBE_INIT);
            r_tube_5      <= 4'(TUBE_INIT);
            r_charge_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
            r_state       <= w_state_next;
            r_sel         <= w_sel_next;
            r_remain      <= w_remain_next;
            r_timer       <= w_timer_next;
            r_tube_0p5    <= w_tube_0p5_next;
            r_tube_1      <= w_tube_1_next;
            r_tube_5      <= w_tube_5_next;
            r_charge_prev <= io_bus.charge_ind;
        end
    end

    // Outputs decode straight from registered state.
    assign io_bus.eject_req  = (r_state == S_EJECT);
    assign io_bus.eject_type = (r_state == S_EJECT) ? r_sel : COIN_NONE;
    assign io_bus.busy       = (r_state != S_IDLE);
    assign io_bus.done       = (r_state == S_DONE);
    assign io_bus.fault      = (r_state == S_FAULT);
    assign io_bus.remain     = r_remain;
    assign io_bus.tube_0p5   = r_tube_0p5;
    assign io_bus.tube_1     = r_tube_1;
    assign io_bus.tube_5     = r_tube_5;

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
// Self-checking bench for change_dispenser. A hopper process acknowledges
// eject requests after a programmable delay and logs the coin types it
// released; a greedy payout model predicts coins, remainder, fault and tubes.
// -----------------------------------------------------------------------------
module tb_change_dispenser;

    localparam int TUBE_INIT   = 10;
    localparam int ACK_TIMEOUT = 200;
    localparam logic [1:0] C_0P5 = 2'b01;
    localparam logic [1:0] C_1   = 2'b11;
    localparam logic [1:0] C_5   = 2'b10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    change_dispenser_if bus();

    change_dispenser #(
        .TUBE_INIT   (TUBE_INIT),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Hopper behaviour
    int         ack_delay = 2;
    bit         hopper_en = 1'b1;
    logic [1:0] ejected[$];

    // Reference model state
    int         m_t5, m_t1, m_th, m_rem;
    bit         m_fault;
    logic [1:0] exp_q[$];

    // Hopper: raises ack ack_delay cycles after seeing a request, holds it
    // until the request drops, and records each coin it releases.
    initial begin
        int cnt = 0;
        bus.eject_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.eject_ack = 1'b0;
                cnt = 0;
            end else if (bus.eject_req && !bus.eject_ack) begin
                if (hopper_en) begin
                    if (cnt >= ack_delay) begin
                        bus.eject_ack = 1'b1;
                        ejected.push_back(bus.eject_type);
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end
            end else if (!bus.eject_req) begin
                bus.eject_ack = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic void model_reset();
        m_t5 = TUBE_INIT; m_t1 = TUBE_INIT; m_th = TUBE_INIT;
        m_rem = 0; m_fault = 1'b0;
        exp_q.delete();
    endfunction

    function automatic int clip15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    function automatic void model_refill(input logic [1:0] t, input int n);
        if (t == C_0P5)    m_th = clip15(m_th + n);
        else if (t == C_1) m_t1 = clip15(m_t1 + n);
        else if (t == C_5) m_t5 = clip15(m_t5 + n);
    endfunction

    // Greedy payout: biggest coin that fits and is in stock, in half-yuan units.
    function automatic void model_payout(input int amt);
        m_rem = amt; m_fault = 1'b0; exp_q.delete();
        while (m_rem > 0) begin
            if (m_rem >= 10 && m_t5 > 0) begin
                exp_q.push_back(C_5); m_rem -= 10; m_t5--;
            end else if (m_rem >= 2 && m_t1 > 0) begin
                exp_q.push_back(C_1); m_rem -= 2; m_t1--;
            end else if (m_th > 0) begin
                exp_q.push_back(C_0P5); m_rem -= 1; m_th--;
            end else begin
                m_fault = 1'b1;
                break;
            end
        end
    endfunction

    function automatic bit seq_equal(input logic [1:0] a[$], input logic [1:0] b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string seq_str(input logic [1:0] a[$]);
        string s = "";
        foreach (a[i]) s = {s, $sformatf("%b ", a[i])};
        return s;
    endfunction

    // ---------------- stimulus helpers (no comparisons) ----------------
    task automatic apply_reset();
        rst_n = 1'b0;
        bus.charge_ind = 1'b0; bus.coin_sum = '0; bus.refill = 1'b0;
        bus.refill_type = '0; bus.refill_cnt = '0; bus.clear = 1'b0;
        hopper_en = 1'b1; ack_delay = 2;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    task automatic do_refill(input logic [1:0] t, input logic [3:0] n);
        bus.refill = 1'b1; bus.refill_type = t; bus.refill_cnt = n;
        @(negedge clk);
        bus.refill = 1'b0; bus.refill_type = '0; bus.refill_cnt = '0;
    endtask

    // Starts a payout and runs until IDLE after done or FAULT; ends on a negedge.
    task automatic do_payout(input int amt, input int budget, output int done_cnt, output bit timed_out);
        ejected.delete();
        done_cnt = 0; timed_out = 1'b1;
        bus.coin_sum = 6'(amt); bus.charge_ind = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            bus.charge_ind = 1'b0;
            if (bus.done) done_cnt++;
            if (bus.fault || !bus.busy) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.charge_ind = 1'b0; bus.coin_sum = '0; bus.refill = 1'b0;
        bus.refill_type = '0; bus.refill_cnt = '0; bus.clear = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.eject_req, bus.eject_type, bus.busy, bus.done, bus.fault} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got req=%b type=%b busy=%b done=%b fault=%b exp all 0",
                     bus.eject_req, bus.eject_type, bus.busy, bus.done, bus.fault);
        end
        checks++;
        if (bus.remain !== 6'd0) begin
            errors++; $display("FAIL reset_remain got %0d exp 0", bus.remain);
        end
        checks++;
        if ({bus.tube_5, bus.tube_1, bus.tube_0p5} !== {4'(TUBE_INIT), 4'(TUBE_INIT), 4'(TUBE_INIT)}) begin
            errors++;
            $display("FAIL reset_tubes got %0d/%0d/%0d exp %0d each", bus.tube_5, bus.tube_1, bus.tube_0p5, TUBE_INIT);
        end
        apply_reset();
    endtask

    task automatic test_basic_payout();
        int dc; bit to;
        logic [1:0] want[$];
        apply_reset();
        want = '{C_5, C_1, C_1, C_1, C_0P5};
        do_payout(17, 500, dc, to);
        checks++;
        if (to) begin errors++; $display("FAIL basic_timeout got no completion exp done"); end
        checks++;
        if (!seq_equal(ejected, want)) begin
            errors++; $display("FAIL basic_seq got %s exp %s", seq_str(ejected), seq_str(want));
        end
        checks++;
        if (dc != 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", dc); end
        checks++;
        if ({bus.remain, bus.tube_5, bus.tube_1, bus.tube_0p5} !== {6'd0, 4'd9, 4'd7, 4'd9}) begin
            errors++;
            $display("FAIL basic_state got remain=%0d tubes %0d/%0d/%0d exp 0 9/7/9",
                     bus.remain, bus.tube_5, bus.tube_1, bus.tube_0p5);
        end
    endtask

    task automatic test_no_five();
        int dc; bit to;
        logic [1:0] want[$];
        apply_reset();
        do_payout(50, 500, dc, to);
        do_payout(50, 500, dc, to);
        checks++;
        if (bus.tube_5 !== 4'd0) begin errors++; $display("FAIL nofive_drain got %0d exp 0", bus.tube_5); end
        for (int i = 0; i < 5; i++) want.push_back(C_1);
        do_payout(10, 500, dc, to);
        checks++;
        if (to || dc != 1) begin errors++; $display("FAIL nofive_done got done=%0d timeout=%0b exp 1 0", dc, to); end
        checks++;
        if (!seq_equal(ejected, want)) begin
            errors++; $display("FAIL nofive_seq got %s exp %s", seq_str(ejected), seq_str(want));
        end
        checks++;
        if (bus.tube_1 !== 4'd5) begin errors++; $display("FAIL nofive_tube1 got %0d exp 5", bus.tube_1); end
    endtask

    task automatic test_fault_no_half();
        int dc; bit to;
        logic [1:0] want[$];
        apply_reset();
        for (int i = 0; i < 10; i++) do_payout(1, 200, dc, to);
        checks++;
        if (bus.tube_0p5 !== 4'd0) begin errors++; $display("FAIL nohalf_drain got %0d exp 0", bus.tube_0p5); end
        want = '{C_1};
        do_payout(3, 500, dc, to);
        checks++;
        if (to || !bus.fault || dc != 0) begin
            errors++; $display("FAIL nohalf_fault got fault=%b done=%0d timeout=%0b exp 1 0 0", bus.fault, dc, to);
        end
        checks++;
        if (!seq_equal(ejected, want)) begin
            errors++; $display("FAIL nohalf_seq got %s exp %s", seq_str(ejected), seq_str(want));
        end
        checks++;
        if (bus.remain !== 6'd1) begin errors++; $display("FAIL nohalf_remain got %0d exp 1", bus.remain); end
        // Clear and refill together from FAULT.
        bus.clear = 1'b1;
        do_refill(C_0P5, 4'd4);
        bus.clear = 1'b0;
        checks++;
        if ({bus.busy, bus.fault, bus.remain, bus.tube_0p5} !== {1'b0, 1'b0, 6'd0, 4'd4}) begin
            errors++;
            $display("FAIL nohalf_clear got busy=%b fault=%b remain=%0d tube_0p5=%0d exp 0 0 0 4",
                     bus.busy, bus.fault, bus.remain, bus.tube_0p5);
        end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        bit seen_fault = 1'b0;
        apply_reset();
        hopper_en = 1'b0;
        bus.coin_sum = 6'd4; bus.charge_ind = 1'b1;
        for (int i = 0; i < ACK_TIMEOUT + 20; i++) begin
            @(negedge clk);
            bus.charge_ind = 1'b0;
            if (bus.eject_req) req_cycles++;
            if (bus.fault) begin seen_fault = 1'b1; break; end
        end
        checks++;
        if (!seen_fault) begin errors++; $display("FAIL timeout_fault got no fault exp fault"); end
        checks++;
        if (req_cycles != ACK_TIMEOUT) begin
            errors++; $display("FAIL timeout_cycles got %0d exp %0d", req_cycles, ACK_TIMEOUT);
        end
        checks++;
        if ({bus.eject_req, bus.remain, bus.tube_1} !== {1'b0, 6'd4, 4'd10}) begin
            errors++;
            $display("FAIL timeout_state got req=%b remain=%0d tube_1=%0d exp 0 4 10", bus.eject_req, bus.remain, bus.tube_1);
        end
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        hopper_en = 1'b1;
        checks++;
        if ({bus.busy, bus.remain} !== {1'b0, 6'd0}) begin
            errors++; $display("FAIL timeout_clear got busy=%b remain=%0d exp 0 0", bus.busy, bus.remain);
        end
    endtask

    task automatic test_zero_and_hold();
        int dcount = 0;
        bit any_req = 1'b0;
        apply_reset();
        bus.coin_sum = 6'd0; bus.charge_ind = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done} !== 2'b10) begin
            errors++; $display("FAIL zero_cycle1 got busy=%b done=%b exp 1 0", bus.busy, bus.done);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL zero_cycle2 got done=%b exp 1", bus.done); end
        if (bus.done) dcount++;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (bus.done) dcount++;
            if (bus.eject_req) any_req = 1'b1;
        end
        bus.charge_ind = 1'b0;
        checks++;
        if (dcount != 1 || any_req) begin
            errors++; $display("FAIL zero_hold got done pulses=%0d eject=%b exp 1 0", dcount, any_req);
        end
    endtask

    task automatic test_refill();
        int dc = 0;
        bit seen_req = 1'b0;
        apply_reset();
        do_refill(C_1, 4'd9);
        checks++;
        if (bus.tube_1 !== 4'd15) begin errors++; $display("FAIL refill_sat got %0d exp 15", bus.tube_1); end
        do_refill(2'b00, 4'd5);
        checks++;
        if ({bus.tube_5, bus.tube_1, bus.tube_0p5} !== {4'd10, 4'd15, 4'd10}) begin
            errors++; $display("FAIL refill_noop got %0d/%0d/%0d exp 10/15/10", bus.tube_5, bus.tube_1, bus.tube_0p5);
        end
        ack_delay = 20;
        bus.coin_sum = 6'd2; bus.charge_ind = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.charge_ind = 1'b0;
            if (bus.eject_req) begin seen_req = 1'b1; break; end
        end
        checks++;
        if (!seen_req) begin errors++; $display("FAIL refill_eject got no eject_req exp eject_req"); end
        do_refill(C_0P5, 4'd3);
        do_refill(C_1, 4'd9);
        for (int i = 0; i < 100 && bus.busy; i++) begin
            @(negedge clk);
            if (bus.done) dc++;
        end
        checks++;
        if ({bus.busy, bus.tube_0p5, bus.tube_1} !== {1'b0, 4'd10, 4'd14} || dc != 1) begin
            errors++;
            $display("FAIL refill_ignored got busy=%b tube_0p5=%0d tube_1=%0d done=%0d exp 0 10 14 1",
                     bus.busy, bus.tube_0p5, bus.tube_1, dc);
        end
        ack_delay = 2;
    endtask

    task automatic test_reset_mid_payout();
        int dc = 0;
        apply_reset();
        ack_delay = 3;
        bus.coin_sum = 6'd17; bus.charge_ind = 1'b1;
        repeat (12) @(negedge clk);
        bus.charge_ind = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.eject_req, bus.remain} !== 9'b0 ||
            {bus.tube_5, bus.tube_1, bus.tube_0p5} !== {4'd10, 4'd10, 4'd10}) begin
            errors++;
            $display("FAIL midreset got busy=%b done=%b req=%b remain=%0d tubes %0d/%0d/%0d exp 0 0 0 0 10/10/10",
                     bus.busy, bus.done, bus.eject_req, bus.remain, bus.tube_5, bus.tube_1, bus.tube_0p5);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dc++;
        end
        checks++;
        if (dc != 0) begin errors++; $display("FAIL midreset_after got %0d active cycles exp 0", dc); end
        model_reset();
    endtask

    task automatic test_random();
        int dc; bit to;
        int amt;
        logic [1:0] rt;
        logic [3:0] rc;
        apply_reset();
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                rt = 2'($urandom_range(0, 3));
                rc = 4'($urandom_range(0, 15));
                do_refill(rt, rc);
                model_refill(rt, int'(rc));
            end
            ack_delay = $urandom_range(0, 3);
            amt = $urandom_range(0, 63);
            model_payout(amt);
            do_payout(amt, 2000, dc, to);
            checks++;
            if (to || bus.fault !== m_fault || dc != (m_fault ? 0 : 1)) begin
                errors++;
                $display("FAIL rand%0d_end amt=%0d got fault=%b done=%0d timeout=%0b exp fault=%b done=%0d",
                         it, amt, bus.fault, dc, to, m_fault, m_fault ? 0 : 1);
            end
            checks++;
            if (!seq_equal(ejected, exp_q)) begin
                errors++; $display("FAIL rand%0d_seq amt=%0d got %s exp %s", it, amt, seq_str(ejected), seq_str(exp_q));
            end
            checks++;
            if (bus.remain !== 6'(m_rem) || bus.tube_5 !== 4'(m_t5) || bus.tube_1 !== 4'(m_t1) || bus.tube_0p5 !== 4'(m_th)) begin
                errors++;
                $display("FAIL rand%0d_state got remain=%0d tubes %0d/%0d/%0d exp %0d %0d/%0d/%0d", it,
                         bus.remain, bus.tube_5, bus.tube_1, bus.tube_0p5, m_rem, m_t5, m_t1, m_th);
            end
            if (bus.fault) begin
                bus.clear = 1'b1;
                @(negedge clk);
                bus.clear = 1'b0;
                m_rem = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_payout();
        test_no_five();
        test_fault_no_half();
        test_timeout();
        test_zero_and_hold();
        test_refill();
        test_reset_mid_payout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion exp finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter TUBE_INIT, default 10, coins loaded into each of the three tubes at reset.
REQ-002 Parameter ACK_TIMEOUT, default 200, maximum cycles eject_req may wait for eject_ack before a jam is declared.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 charge_ind  input  1  level from the vending FSM; a rising edge requests a payout.
REQ-006 coin_sum  input  6  payout amount in Q1 units (value x2), sampled on the charge_ind rising edge.
REQ-007 eject_ack  input  1  hopper acknowledge; high once one coin has been physically released.
REQ-008 refill  input  1  one-cycle refill strobe.
REQ-009 refill_type  input  2  tube to refill: 01 = 0.5 yuan, 11 = 1 yuan, 10 = 5 yuan.
REQ-010 refill_cnt  input  4  number of coins added on refill.
REQ-011 clear  input  1  one-cycle strobe that leaves FAULT.
REQ-012 eject_req  output  1  request to the hopper to release one coin.
REQ-013 eject_type  output  2  coin type for eject_req; same encoding as refill_type.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse when the payout completes.
REQ-016 fault  output  1  high while in FAULT.
REQ-017 remain  output  6  unpaid amount in Q1 units.
REQ-018 tube_0p5, tube_1, tube_5  output  4 each  current tube inventory.

Function
REQ-019 State machine states: IDLE, SELECT, EJECT, GAP, DONE, FAULT; IDLE is the only start state.
REQ-020 In IDLE, a registered rising edge of charge_ind (0 in the previous cycle, 1 now) SHALL load remain <= coin_sum and move to SELECT; a charge_ind held high SHALL NOT retrigger.
REQ-021 A charge_ind rising edge seen outside IDLE SHALL be ignored.
REQ-022 In SELECT, remain = 0 SHALL move to DONE.
REQ-023 Otherwise SELECT SHALL choose, in priority order, 5 yuan if remain >= 10 and tube_5 > 0, else 1 yuan if remain >= 2 and tube_1 > 0, else 0.5 yuan if tube_0p5 > 0, and then move to EJECT.
REQ-024 SELECT SHALL move to FAULT when no coin qualifies.
REQ-025 In EJECT, eject_req SHALL be 1 and eject_type SHALL be the selected type, held stable until the state is left.
REQ-026 eject_ack = 1 in EJECT SHALL, in the same edge, subtract the coin value (10, 2 or 1) from remain, decrement that tube by 1, and move to GAP.
REQ-027 An ACK_TIMEOUT-cycle counter SHALL run in EJECT; reaching ACK_TIMEOUT without eject_ack SHALL move to FAULT with remain unchanged.
REQ-028 In GAP, eject_req SHALL be 0; the block SHALL wait for eject_ack = 0 and then move to SELECT (minimum one GAP cycle).
REQ-029 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-030 FAULT SHALL hold remain and the tube counts; clear SHALL move to IDLE and zero remain.
REQ-031 refill SHALL add refill_cnt to the chosen tube, saturating at 15; refill_type 00 is a no-op.
REQ-032 refill SHALL be honoured only in IDLE or FAULT and ignored while a payout is in progress.
REQ-033 Simultaneous refill and clear in FAULT SHALL apply both in the same edge.
REQ-034 remain SHALL never underflow; subtraction happens only after the coin-selection checks that guarantee remain >= coin value.
REQ-035 Payout latency SHALL be 1 SELECT cycle plus EJECT wait plus GAP per coin, plus 1 cycle for DONE.

Reset
REQ-036 While rst_n = 0, and immediately on assertion: state = IDLE, remain = 0, eject_req = 0, eject_type = 00, busy = 0, done = 0, fault = 0, each tube = TUBE_INIT, timeout counter = 0, and the charge_ind edge register = 0.
REQ-037 Reset asserted mid-payout SHALL abort the payout with no done pulse; the tube counts return to TUBE_INIT.

Verification
REQ-038 coin_sum = 17 (8.5 yuan), tubes at 10, hopper acks 2 cycles after each request -> eject sequence 10, 11, 11, 11, 01; done pulses once; remain = 0; tubes become 5/9, 1/7, 0.5/9.
REQ-039 tube_5 = 0, coin_sum = 10 -> five 1-yuan ejects; done pulses; tube_1 = 5.
REQ-040 tube_0p5 = 0, coin_sum = 3 -> one 1-yuan eject, then fault = 1 with remain = 1; clear -> IDLE with remain = 0.
REQ-041 eject_ack held at 0 -> fault after ACK_TIMEOUT cycles; remain unchanged; eject_req = 0 in FAULT.
REQ-042 coin_sum = 0 with a charge_ind rising edge -> done two cycles later with no eject; charge_ind held high for 50 cycles -> only one payout.
REQ-043 refill of 11 with refill_cnt 9 while tube_1 = 10 -> tube_1 = 15 (saturates); the same refill during EJECT is ignored.
